// File: rtl/updown_counter.sv
// Parameterised up/down counter with wrap or saturate at 0 and MAX_COUNT.
// Outputs a one-cycle boundary pulse, a sticky overflow flag and limit decodes.
module updown_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             overflow,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             overflow_nxt;
    logic             hit_max;
    logic             hit_zero;

    // >= guards against a count ever sitting above a non-power-of-two limit.
    assign hit_max  = (count >= MAX_COUNT);
    assign hit_zero = (count == '0);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        count_nxt    = count;
        wrap_nxt     = 1'b0;
        overflow_nxt = overflow;

        if (clear) begin
            count_nxt    = '0;
            overflow_nxt = 1'b0;
        end else if (load) begin
            count_nxt = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (hit_max) begin
                    count_nxt    = SATURATE ? count : '0;
                    wrap_nxt     = 1'b1;
                    overflow_nxt = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (hit_zero) begin
                    count_nxt    = SATURATE ? count : MAX_COUNT;
                    wrap_nxt     = 1'b1;
                    overflow_nxt = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            wrap     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign at_max  = (count == MAX_COUNT);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter: wrap (4-bit, limit 9),
// saturate (4-bit, limit 9) and full-range 8-bit instances on one clock.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic [7:0] load_value8 = '0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;

    logic [3:0] w_count, s_count;
    logic [7:0] b_count;
    logic       w_wrap, w_ovf, w_max, w_zero;
    logic       s_wrap, s_ovf, s_max, s_zero;
    logic       b_wrap, b_ovf, b_max, b_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .count(w_count), .wrap(w_wrap), .overflow(w_ovf),
        .at_max(w_max), .at_zero(w_zero)
    );

    updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .count(s_count), .wrap(s_wrap), .overflow(s_ovf),
        .at_max(s_max), .at_zero(s_zero)
    );

    updown_counter #(.WIDTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value8), .enable(enable), .up_down(up_down),
        .count(b_count), .wrap(b_wrap), .overflow(b_ovf),
        .at_max(b_max), .at_zero(b_zero)
    );

    // Advance one edge and settle; inputs changed afterwards apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string name, input logic [3:0] ec, input logic ew,
                         input logic eo);
        n_checks++;
        if (w_count !== ec || w_wrap !== ew || w_ovf !== eo ||
            w_max !== (ec == 4'd9) || w_zero !== (ec == 4'd0)) begin
            n_fail++;
            $display("FAIL %s: count=%0d wrap=%b ovf=%b at_max=%b at_zero=%b, expected count=%0d wrap=%b ovf=%b",
                     name, w_count, w_wrap, w_ovf, w_max, w_zero, ec, ew, eo);
        end
    endtask

    task automatic chk_s(input string name, input logic [3:0] ec, input logic ew,
                         input logic eo);
        n_checks++;
        if (s_count !== ec || s_wrap !== ew || s_ovf !== eo ||
            s_max !== (ec == 4'd9) || s_zero !== (ec == 4'd0)) begin
            n_fail++;
            $display("FAIL %s: count=%0d wrap=%b ovf=%b at_max=%b at_zero=%b, expected count=%0d wrap=%b ovf=%b",
                     name, s_count, s_wrap, s_ovf, s_max, s_zero, ec, ew, eo);
        end
    endtask

    task automatic do_reset();
        enable = 1'b0; clear = 1'b0; load = 1'b0; up_down = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        chk_w("reset_w", 4'd0, 1'b0, 1'b0);
        chk_s("reset_s", 4'd0, 1'b0, 1'b0);
        n_checks++;
        if (b_count !== 8'd0 || b_wrap !== 1'b0 || b_ovf !== 1'b0 || b_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: count=%0d wrap=%b ovf=%b, expected 0 0 0", b_count, b_wrap, b_ovf);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_c;
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_c = 4'(i % 10);
            chk_w($sformatf("up_%0d", i), exp_c, i == 10, i >= 10);
        end
    endtask

    task automatic test_count_down();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_w("clear_beats_enable", 4'd0, 1'b0, 1'b0);
        up_down = 1'b0;
        step();
        chk_w("down_wrap_to_max", 4'd9, 1'b1, 1'b1);
        step();
        chk_w("down_after_wrap", 4'd8, 1'b0, 1'b1);
        // Direction changes take effect on the very next enabled edge.
        up_down = 1'b1;
        step();
        chk_w("dir_up", 4'd9, 1'b0, 1'b1);
        up_down = 1'b0;
        step();
        chk_w("dir_down", 4'd8, 1'b0, 1'b1);
    endtask

    task automatic test_load();
        enable = 1'b1; up_down = 1'b1;
        load = 1'b1; load_value = 4'd15;
        step();
        chk_w("load_clamp", 4'd9, 1'b0, 1'b1);
        load_value = 4'd3;
        step();
        chk_w("load_beats_enable", 4'd3, 1'b0, 1'b1);
        clear = 1'b1;
        step();
        chk_w("clear_beats_load", 4'd0, 1'b0, 1'b0);
        clear = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        load = 1'b1; load_value = 4'd9;
        step();
        load = 1'b0;
        chk_s("sat_load9", 4'd9, 1'b0, 1'b0);
        enable = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_s($sformatf("sat_hold_%0d", i), 4'd9, 1'b1, 1'b1);
        end
        up_down = 1'b0;
        step();
        chk_s("sat_down", 4'd8, 1'b0, 1'b1);
        load = 1'b1; load_value = 4'd0;
        step();
        load = 1'b0;
        step();
        chk_s("sat_hold_zero", 4'd0, 1'b1, 1'b1);
        enable = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        load = 1'b1; load_value = 4'd9;
        step();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        step();
        chk_w("wrap_before_hold", 4'd0, 1'b1, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_w($sformatf("hold_%0d", i), 4'd0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; load_value = 4'd5;
        step();
        load = 1'b0;
        chk_w("pre_reset_5", 4'd5, 1'b0, 1'b0);
        enable = 1'b1; up_down = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_w("async_reset_immediate", 4'd0, 1'b0, 1'b0);
        step();
        chk_w("reset_ignores_enable", 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        chk_w("first_after_release", 4'd1, 1'b0, 1'b0);
        // Reset during a wrap pulse kills it with no residual pulse afterwards.
        enable = 1'b0; load = 1'b1; load_value = 4'd9;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk_w("wrap_pulse_live", 4'd0, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_w("wrap_pulse_aborted", 4'd0, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk_w("no_residual_wrap", 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_width8();
        int wraps = 0;
        int bad = 0;
        do_reset();
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (b_wrap === 1'b1) wraps++;
            if (b_count !== 8'(i % 256) || b_wrap !== (i == 256)) bad++;
        end
        n_checks++;
        if (wraps != 1 || bad != 0 || b_count !== 8'd0 || b_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL width8_sweep: wraps=%0d bad_cycles=%0d count=%0d ovf=%b, expected wraps=1 bad=0 count=0 ovf=1",
                     wraps, bad, b_count, b_ovf);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (b_count !== 8'd0 || b_wrap !== 1'b0 || b_ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL width8_hold_%0d: count=%0d wrap=%b ovf=%b, expected 0 0 1",
                         i, b_count, b_wrap, b_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_saturate();
        test_hold();
        test_async_reset();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1: terminal value; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset_n  input  1  reset, asynchronous assert and active-low.
REQ-006 Port clear  input  1  synchronous clear to 0, active-high.
REQ-007 Port load  input  1  synchronous load of load_value, active-high.
REQ-008 Port load_value  input  WIDTH  value to load.
REQ-009 Port enable  input  1  count enable, active-high.
REQ-010 Port up_down  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 Port count  output  WIDTH  registered counter value, always within 0..MAX_COUNT.
REQ-012 Port wrap  output  1  registered one-cycle pulse marking a boundary event.
REQ-013 Port overflow  output  1  registered sticky flag for any boundary event since the last clear or reset.
REQ-014 Port at_max  output  1  combinational: count == MAX_COUNT.
REQ-015 Port at_zero  output  1  combinational: count == 0.

Function
REQ-016 Per-edge priority: clear > load > enable > hold.
REQ-017 Clear: count <= 0, wrap <= 0, overflow <= 0.
REQ-018 Load: count <= min(load_value, MAX_COUNT) and wrap <= 0; overflow is unchanged; enable is ignored that cycle.
REQ-019 Enable, up_down=1, count < MAX_COUNT: count <= count+1 and wrap <= 0.
REQ-020 Enable, up_down=0, count > 0: count <= count-1 and wrap <= 0.
REQ-021 Up at the limit (count == MAX_COUNT), SATURATE=0: count <= 0, wrap <= 1, overflow <= 1.
REQ-022 Down at the limit (count == 0), SATURATE=0: count <= MAX_COUNT, wrap <= 1, overflow <= 1.
REQ-023 Either limit with SATURATE=1: count holds, wrap <= 1, overflow <= 1.
REQ-024 Enable low, with no clear or load: count and overflow hold, wrap <= 0.
REQ-025 wrap is high for exactly the one cycle after the boundary edge, so it aligns with the new count value; back-to-back boundary events give consecutive wrap cycles.
REQ-026 Count arithmetic is WIDTH bits, with no intermediate wrap through 2**WIDTH when MAX_COUNT < 2**WIDTH-1.
REQ-027 up_down may change on any cycle; it takes effect on the next enabled edge, with no extra latency.
REQ-028 Latency: every control input affects count, wrap and overflow at the next rising clk edge; at_max and at_zero follow count with zero latency.

Reset
REQ-029 reset_n low forces count=0, wrap=0, overflow=0 immediately, independent of clk.
REQ-030 While reset_n is low, all other inputs are ignored.
REQ-031 Reset deassertion is synchronised by the integrator; the first state update occurs on the first rising clk edge with reset_n high.
REQ-032 Reset asserted mid-count or mid-wrap-pulse aborts the pulse; no residual wrap follows release.

Verification (WIDTH=4, MAX_COUNT=9 unless stated)
REQ-033 Reset then enable=1, up_down=1 for 12 cycles -> count 1..9,0,1,2; wrap high only with count=0; overflow=1 from that cycle on.
REQ-034 From count=0: enable=1, up_down=0 -> count=9, wrap=1, at_max=1; the next cycle gives count=8, wrap=0.
REQ-035 SATURATE=1, load 9 then count up 3 cycles -> count stays 9, wrap=1 each cycle, overflow=1; then count down -> 8.
REQ-036 load=1 with load_value=15 -> count=9, the limit; clear=1 and load=1 together -> count=0, overflow=0.
REQ-037 Assert reset_n=0 between clk edges at count=5 -> count=0 before the next edge; after release with enable=1, up -> count=1.
REQ-038 WIDTH=8 with default MAX_COUNT, enable up for 256 cycles -> one wrap pulse at 255->0; hold enable=0 -> count is stable and wrap=0.
